// File: rtl/arbitro_pkg.sv
// Shared types and dual-rail helpers for the adder arbiter.
// Each operand bit occupies a rail pair: [2i+1] is the true rail, [2i] the false rail.
`timescale 1ns/1ps
package arbitro_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        NULL = 2'd2
    } state_t;

    localparam logic [1:0] NULL_PAIR = 2'b00;
    localparam logic [1:0] ONE       = 2'b10;
    localparam logic [1:0] ZERO      = 2'b01;

    function automatic logic [7:0] encode_dr(input logic [3:0] value);
        logic [7:0] rails;
        rails = '0;
        for (int i = 0; i < 4; i++) begin
            rails[2*i +: 2] = value[i] ? ONE : ZERO;
        end
        return rails;
    endfunction

    function automatic logic [3:0] decode_dr(input logic [7:0] rails);
        logic [3:0] value;
        value = '0;
        for (int i = 0; i < 4; i++) begin
            value[i] = rails[2*i+1];
        end
        return value;
    endfunction

endpackage

// File: rtl/arbitro_somador_detector.sv
// Classifies the dual-rail sum word returned by the adder.
// complete: every pair is a valid code; empty: every pair is NULL; illegal: some pair is 11.
`timescale 1ns/1ps
module detector_completude
    import arbitro_pkg::*;
(
    input  logic [7:0] soma,
    output logic       complete,
    output logic       empty,
    output logic       illegal
);

    always_comb begin
        complete = 1'b1;
        empty    = 1'b1;
        illegal  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (soma[2*i +: 2] == NULL_PAIR) begin
                complete = 1'b0;
            end else begin
                empty = 1'b0;
            end
            if (soma[2*i +: 2] == 2'b11) begin
                illegal  = 1'b1;
                complete = 1'b0;
            end
        end
    end

endmodule

// File: rtl/arbitro_somador.sv
// Round-robin front end for a shared dual-rail 4-bit adder: grants one of two
// requesters, runs the DATA/NULL return-to-zero handshake and returns the decoded sum.
`timescale 1ns/1ps
module arbitro_somador
    import arbitro_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    input  logic       cin0,
    input  logic       cin1,
    output logic       ack0,
    output logic       ack1,
    output logic [3:0] res,
    output logic       err,
    output logic [7:0] ad_a,
    output logic [7:0] ad_b,
    output logic [1:0] ad_cin,
    input  logic [7:0] ad_soma
);

    // Phase timer counts down from TIMEOUT-1; a phase lasting TIMEOUT cycles expires at zero.
    localparam logic [7:0] CNT_LOAD = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic       ptr;
    logic       gnt;
    logic       gnt_sel;
    logic       grant;
    logic       done;
    logic       set_err;
    logic       load_cnt;
    logic [7:0] cnt;
    logic       complete;
    logic       empty;
    logic       illegal;

    detector_completude u_detector (
        .soma     (ad_soma),
        .complete (complete),
        .empty    (empty),
        .illegal  (illegal)
    );

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        gnt_sel   = ptr;
        done      = 1'b0;
        set_err   = 1'b0;
        load_cnt  = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant     = 1'b1;
                    gnt_sel   = (req0 && req1) ? ptr : req1;
                    state_nxt = DATA;
                    load_cnt  = 1'b1;
                end
            end
            DATA: begin
                if (illegal) begin
                    set_err   = 1'b1;
                    state_nxt = NULL;
                    load_cnt  = 1'b1;
                end else if (complete) begin
                    done      = 1'b1;
                    state_nxt = NULL;
                    load_cnt  = 1'b1;
                end else if (cnt == '0) begin
                    set_err   = 1'b1;
                    state_nxt = NULL;
                    load_cnt  = 1'b1;
                end
            end
            NULL: begin
                // An illegal word while draining keeps us here; the timer still bounds the stay.
                if (illegal) begin
                    set_err = 1'b1;
                end
                if (empty) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    set_err   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= 1'b0;
            gnt    <= 1'b0;
            cnt    <= '0;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            res    <= '0;
            err    <= 1'b0;
            ad_a   <= '0;
            ad_b   <= '0;
            ad_cin <= '0;
        end else begin
            state <= state_nxt;
            ack0  <= done && !gnt;
            ack1  <= done && gnt;
            err   <= err | set_err;
            if (done) begin
                res <= decode_dr(ad_soma);
            end
            if (load_cnt) begin
                cnt <= CNT_LOAD;
            end else if (cnt != '0) begin
                cnt <= cnt - 8'd1;
            end
            // The ad_* registers double as the operand latch for the whole DATA phase.
            if (grant) begin
                gnt    <= gnt_sel;
                ptr    <= ~gnt_sel;
                ad_a   <= encode_dr(gnt_sel ? a1 : a0);
                ad_b   <= encode_dr(gnt_sel ? b1 : b0);
                ad_cin <= (gnt_sel ? cin1 : cin0) ? ONE : ZERO;
            end else if (state_nxt != DATA) begin
                ad_a   <= '0;
                ad_b   <= '0;
                ad_cin <= '0;
            end
        end
    end

endmodule

// File: tb/tb_arbitro_somador.sv
// Self-checking bench for arbitro_somador: directed scenarios plus a randomized
// two-requester scoreboard, driving a behavioural dual-rail adder model.
`timescale 1ns/1ps
module tb_arbitro_somador;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic       cin0 = 1'b0, cin1 = 1'b0;
    logic       ack0, ack1, err;
    logic [3:0] res;
    logic [7:0] ad_a, ad_b, ad_soma;
    logic [1:0] ad_cin;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // adder model: mode 0 = computes after dly cycles, 1 = drives pair 0 as 11, 2 = never completes
    int mode = 0;
    int dly = 0;
    int age = 0;

    arbitro_somador #(.TIMEOUT(TMO)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .req1    (req1),
        .a0      (a0),
        .b0      (b0),
        .a1      (a1),
        .b1      (b1),
        .cin0    (cin0),
        .cin1    (cin1),
        .ack0    (ack0),
        .ack1    (ack1),
        .res     (res),
        .err     (err),
        .ad_a    (ad_a),
        .ad_b    (ad_b),
        .ad_cin  (ad_cin),
        .ad_soma (ad_soma)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        age <= (ad_a != 8'd0) ? age + 1 : 0;
    end

    function automatic logic [7:0] dual(input logic [3:0] v);
        logic [7:0] r;
        for (int i = 0; i < 4; i++) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
        return r;
    endfunction

    function automatic logic [3:0] trues(input logic [7:0] d);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = d[2*i+1];
        return r;
    endfunction

    always_comb begin
        ad_soma = '0;
        if (ad_a != 8'd0) begin
            if (mode == 1) ad_soma = 8'b00000011;
            else if (mode == 0 && age >= dly)
                ad_soma = dual(4'(trues(ad_a) + trues(ad_b) + {3'b000, ad_cin[1]}));
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic wait_ack(input string tag, input int k, input int budget, output int lat);
        int other;
        other = 0;
        lat = -1;
        for (int i = 1; i <= budget && lat < 0; i++) begin
            @(negedge clk);
            if (k == 0 ? ack1 : ack0) other++;
            if (k == 0 ? ack0 : ack1) lat = i;
        end
        if (lat < 0) chk({tag, "_tmo"}, 0, 1);
        chk({tag, "_other"}, other, 0);
    endtask

    // random-phase scoreboard
    bit         pend [2];
    int         raise_cyc [2];
    logic [3:0] exp_sum [2];
    int         last_k = -1;
    int         last_cyc = 0;
    int         n_acks = 0;

    task automatic rnd_step(input bit allow_new);
        logic [3:0] ra, rb;
        logic       rc;
        logic       hit;
        logic       starve;
        @(negedge clk);
        if (ack0 || ack1) chk("rnd_onehot", int'(ack0) + int'(ack1), 1);
        for (int k = 0; k < 2; k++) begin
            hit = (k == 0) ? ack0 : ack1;
            if (hit) begin
                chk("rnd_pending", 32'(pend[k]), 1);
                chk("rnd_res", res, exp_sum[k]);
                starve = (last_k == k) && pend[1-k] && (raise_cyc[1-k] <= last_cyc);
                chk("rnd_rr", starve, 0);
                last_k = k;
                last_cyc = cyc;
                pend[k] = 1'b0;
                n_acks++;
                if (k == 0) req0 = 1'b0; else req1 = 1'b0;
            end
        end
        if ($urandom_range(0, 3) == 0) dly = $urandom_range(0, 2);
        for (int k = 0; k < 2; k++) begin
            if (allow_new && !pend[k] && $urandom_range(0, 2) == 0) begin
                ra = 4'($urandom);
                rb = 4'($urandom);
                rc = 1'($urandom);
                exp_sum[k] = 4'(ra + rb + {3'b000, rc});
                pend[k] = 1'b1;
                raise_cyc[k] = cyc;
                if (k == 0) begin a0 = ra; b0 = rb; cin0 = rc; req0 = 1'b1; end
                else        begin a1 = ra; b1 = rb; cin1 = rc; req1 = 1'b1; end
            end
        end
    endtask

    initial begin
        int lat;
        int acks;
        int who;
        int waited;
        logic [3:0] exp_rr [2];

        // reset values
        do_reset();
        chk("rst_ad", {ad_a, ad_b, ad_cin}, 0);
        chk("rst_ack", {ack0, ack1}, 0);
        chk("rst_res", res, 0);
        chk("rst_err", err, 0);

        // 3 + 4 + 0 from requester 0, operand change after grant must be ignored
        mode = 0; dly = 0;
        a0 = 4'd3; b0 = 4'd4; cin0 = 1'b0; req0 = 1'b1;
        tick(1);
        chk("t1_ad_a", ad_a, 8'b01011010);
        chk("t1_ad_b", ad_b, 8'b01100101);
        chk("t1_ad_cin", ad_cin, 2'b01);
        chk("t1_ack_early", ack0, 0);
        a0 = 4'd0;
        tick(1);
        chk("t1_ack0", ack0, 1);
        chk("t1_ack1", ack1, 0);
        chk("t1_res", res, 7);
        req0 = 1'b0;
        tick(1);
        chk("t1_ack_pulse", ack0, 0);
        chk("t1_ad_null", ad_a, 0);

        // 15 + 0 + 1 wraps to 0; req1 dropped after grant still gets its ack
        a1 = 4'd15; b1 = 4'd0; cin1 = 1'b1; req1 = 1'b1;
        tick(1);
        chk("t2_ad_a", ad_a, 8'b10101010);
        chk("t2_ad_cin", ad_cin, 2'b10);
        req1 = 1'b0;
        tick(1);
        chk("t2_ack1", ack1, 1);
        chk("t2_ack0", ack0, 0);
        chk("t2_res", res, 0);
        tick(1);

        // illegal pair in DATA: error, no ack, then re-arbitrated and completed
        mode = 1;
        a0 = 4'd5; b0 = 4'd6; cin0 = 1'b1; req0 = 1'b1;
        tick(2);
        chk("ill_err", err, 1);
        chk("ill_noack", ack0, 0);
        chk("ill_null", ad_a, 0);
        mode = 0;
        wait_ack("ill_retry", 0, 12, lat);
        chk("ill_retry_lat", lat, 3);
        chk("ill_retry_res", res, 12);
        chk("ill_sticky", err, 1);
        req0 = 1'b0;
        tick(1);

        // reset while in DATA
        dly = 2;
        a0 = 4'd9; b0 = 4'd9; cin0 = 1'b0; req0 = 1'b1;
        tick(1);
        chk("rd_data", ad_a, 8'b10010110);
        rst_n = 1'b0; req0 = 1'b0;
        tick(1);
        chk("rd_ad", {ad_a, ad_b, ad_cin}, 0);
        chk("rd_ack", {ack0, ack1}, 0);
        chk("rd_res", res, 0);
        chk("rd_err", err, 0);
        rst_n = 1'b1;
        acks = 0;
        repeat (6) begin
            tick(1);
            acks += int'(ack0) + int'(ack1);
        end
        chk("rd_noack", acks, 0);

        // adder never completes: timeout after TMO cycles of DATA
        mode = 2; dly = 0;
        a0 = 4'd2; b0 = 4'd2; cin0 = 1'b1; req0 = 1'b1;
        tick(TMO);
        chk("to_still_data", ad_a, 8'b01011001);
        chk("to_err_early", err, 0);
        tick(1);
        chk("to_err", err, 1);
        chk("to_noack", ack0, 0);
        chk("to_null", ad_a, 0);
        mode = 0;
        wait_ack("to_retry", 0, 12, lat);
        chk("to_retry_lat", lat, 3);
        chk("to_retry_res", res, 5);
        req0 = 1'b0;
        tick(1);

        // randomized contention against the scoreboard
        do_reset();
        mode = 0;
        for (int i = 0; i < 400; i++) rnd_step(1'b1);
        for (int i = 0; i < 30; i++) rnd_step(1'b0);
        chk("rnd_drain", 32'(pend[0] | pend[1]), 0);
        chk("rnd_some_acks", 32'(n_acks > 40), 1);

        // both requesting from reset: strict alternation, 3 cycles per op
        rst_n = 1'b0; dly = 0;
        a0 = 4'd1; b0 = 4'd2; cin0 = 1'b0; exp_rr[0] = 4'd3;
        a1 = 4'd7; b1 = 4'd8; cin1 = 1'b1; exp_rr[1] = 4'd0;
        req0 = 1'b1; req1 = 1'b1;
        tick(2);
        rst_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            who = -1;
            waited = 0;
            while (who < 0 && waited < 12) begin
                tick(1);
                waited++;
                if (ack0) who = 0;
                else if (ack1) who = 1;
            end
            if (who < 0) begin
                chk("rr_tmo", 0, 1);
                break;
            end
            chk("rr_order", who, n % 2);
            chk("rr_onehot", int'(ack0) + int'(ack1), 1);
            chk("rr_res", res, exp_rr[who]);
            chk("rr_gap", waited, (n == 0) ? 2 : 3);
            if (who == 0) begin
                a0 = 4'($urandom); b0 = 4'($urandom); cin0 = 1'($urandom);
                exp_rr[0] = 4'(a0 + b0 + {3'b000, cin0});
            end else begin
                a1 = 4'($urandom); b1 = 4'($urandom); cin1 = 1'($urandom);
                exp_rr[1] = 4'(a1 + b1 + {3'b000, cin1});
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
